zbank_bridge: RTL and testbench

- Sequences Z80 accesses to the banked 32 KB window (Z80 0x8000-0xFFFF) onto the 68000 bus.
- Holds the 9-bit bank register, which the Z80 loads serially through 0x6000-0x60FF.
- For each window access: stalls the Z80 with WAIT, requests and acquires the 68k bus (BR/BG/BGACK), runs one byte cycle with AS/UDS/LDS/RW, waits for DTACK or a timeout, returns read data, then releases the bus.
- Sits beside the arbiter in the FC1004-class ASIC. All signals here are active-high; pad-level inversion happens at the top level.

---
 rtl/zbank_bridge_if.sv | 42 ++++
 rtl/zbank_bridge.sv | 188 ++++++++++++++++++
 tb/tb_zbank_bridge.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zbank_bridge_if.sv
// Z80-side and 68000-side signal bundle for the banked-window bridge.
// The bridge sits on the slave modport; the Z80/68k environment uses master.
interface zbank_bridge_if;
  logic [15:0] ZA;
  logic [7:0]  ZD_i;
  logic        ZMREQ;
  logic        ZRD;
  logic        ZWR;
  logic [7:0]  ZD_o;
  logic        ZD_oe;
  logic        ZWAIT;

  logic        BR;
  logic        BG;
  logic        BGACK;
  logic        AS_i;
  logic        DTACK;
  logic [22:0] VA_o;
  logic        VA_oe;
  logic        strobe_oe;
  logic        AS_o;
  logic        UDS_o;
  logic        LDS_o;
  logic        RW_o;
  logic [15:0] VD_i;
  logic [15:0] VD_o;
  logic        VD_oe;

  modport slave (
    input  ZA, ZD_i, ZMREQ, ZRD, ZWR,
    input  BG, AS_i, DTACK, VD_i,
    output ZD_o, ZD_oe, ZWAIT,
    output BR, BGACK, VA_o, VA_oe, strobe_oe, AS_o, UDS_o, LDS_o, RW_o, VD_o, VD_oe
  );

  modport master (
    output ZA, ZD_i, ZMREQ, ZRD, ZWR,
    output BG, AS_i, DTACK, VD_i,
    input  ZD_o, ZD_oe, ZWAIT,
    input  BR, BGACK, VA_o, VA_oe, strobe_oe, AS_o, UDS_o, LDS_o, RW_o, VD_o, VD_oe
  );
endinterface

// File: rtl/zbank_bridge.sv
// Maps Z80 accesses to 0x8000-0xFFFF onto one 68000 byte cycle via a
// serially loaded 9-bit bank register, with bus request and DTACK timeouts.
//
//   state  | meaning
//   IDLE   | waiting for a window hit; ZWAIT follows hit combinationally
//   REQ    | BR asserted, waiting for BG with the previous master idle
//   OWN    | bus owned, address and RW driven for one setup cycle
//   STROBE | AS and UDS/LDS asserted, waiting for DTACK or timeout
//   HOLD   | strobes released, bus still driven
//   REL    | bus released
//   DONE   | Z80 released, waiting for ZMREQ to drop
module zbank_bridge #(
  parameter int TIMEOUT    = 128,
  parameter int BG_TIMEOUT = 1024
) (
  input  logic          MCLK,
  input  logic          RESET,
  zbank_bridge_if.slave zb,
  output logic [8:0]    bank,
  output logic          timeout_flag
);

  localparam int DT_W = $clog2(TIMEOUT + 1);
  localparam int BG_W = $clog2(BG_TIMEOUT + 1);
  localparam logic [DT_W-1:0] DT_LAST = DT_W'(TIMEOUT - 1);
  localparam logic [BG_W-1:0] BG_LAST = BG_W'(BG_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OWN,
    S_STROBE,
    S_HOLD,
    S_REL,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DT_W-1:0] dt_cnt;
  logic [BG_W-1:0] bg_cnt;
  logic [7:0]      zd_q;
  logic [8:0]      bank_q;
  logic            bank_stb;
  logic            bank_stb_q;
  logic            hit;
  logic            grant;
  logic            dt_expire;
  logic            bg_expire;

  assign hit       = zb.ZMREQ & (zb.ZRD | zb.ZWR) & zb.ZA[15];
  assign bank_stb  = zb.ZMREQ & zb.ZWR & (zb.ZA[15:8] == 8'h60);
  // The previous master must have finished its cycle before we take the bus.
  assign grant     = zb.BG & ~zb.AS_i;
  assign dt_expire = (dt_cnt == DT_LAST) & ~zb.DTACK;
  assign bg_expire = (bg_cnt == BG_LAST) & ~grant;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (hit) state_nxt = S_REQ;
      S_REQ: begin
        if (grant) begin
          state_nxt = S_OWN;
        end else if (bg_expire) begin
          state_nxt = S_DONE;
        end
      end
      S_OWN:    state_nxt = S_STROBE;
      S_STROBE: if (zb.DTACK || dt_expire) state_nxt = S_HOLD;
      S_HOLD:   state_nxt = S_REL;
      S_REL:    state_nxt = S_DONE;
      S_DONE:   if (!zb.ZMREQ) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    zb.ZWAIT     = 1'b0;
    zb.ZD_oe     = 1'b0;
    zb.BR        = 1'b0;
    zb.BGACK     = 1'b0;
    zb.VA_oe     = 1'b0;
    zb.strobe_oe = 1'b0;
    zb.AS_o      = 1'b0;
    zb.UDS_o     = 1'b0;
    zb.LDS_o     = 1'b0;
    zb.RW_o      = 1'b1;
    zb.VD_oe     = 1'b0;
    timeout_flag = 1'b0;
    if (!RESET) begin
      case (state)
        S_IDLE: zb.ZWAIT = hit;
        S_REQ: begin
          zb.ZWAIT     = 1'b1;
          zb.BR        = 1'b1;
          timeout_flag = bg_expire;
        end
        S_OWN: begin
          zb.ZWAIT     = 1'b1;
          zb.BGACK     = 1'b1;
          zb.VA_oe     = 1'b1;
          zb.strobe_oe = 1'b1;
          zb.RW_o      = zb.ZRD;
        end
        S_STROBE: begin
          zb.ZWAIT     = 1'b1;
          zb.BGACK     = 1'b1;
          zb.VA_oe     = 1'b1;
          zb.strobe_oe = 1'b1;
          zb.RW_o      = zb.ZRD;
          zb.AS_o      = 1'b1;
          zb.UDS_o     = ~zb.ZA[0];
          zb.LDS_o     = zb.ZA[0];
          zb.VD_oe     = ~zb.ZRD;
          timeout_flag = dt_expire;
        end
        S_HOLD: begin
          zb.ZWAIT     = 1'b1;
          zb.BGACK     = 1'b1;
          zb.VA_oe     = 1'b1;
          zb.strobe_oe = 1'b1;
          zb.RW_o      = zb.ZRD;
        end
        S_REL:  zb.ZWAIT = 1'b1;
        S_DONE: zb.ZD_oe = zb.ZRD;
        default: begin
          zb.ZWAIT = 1'b0;
        end
      endcase
    end
  end

  // Bus address tracks bank combinationally so a forced bank write shows at once.
  assign zb.VA_o = RESET ? 23'h0 : {bank_q, zb.ZA[14:1]};
  assign zb.VD_o = RESET ? 16'h0 : {zb.ZD_i, zb.ZD_i};
  assign zb.ZD_o = RESET ? 8'h00 : zd_q;
  assign bank    = bank_q;

  always_ff @(posedge MCLK) begin
    if (RESET || state != S_STROBE) begin
      dt_cnt <= '0;
    end else if (dt_cnt != '1) begin
      dt_cnt <= dt_cnt + DT_W'(1);
    end
  end

  always_ff @(posedge MCLK) begin
    if (RESET || state != S_REQ) begin
      bg_cnt <= '0;
    end else if (bg_cnt != '1) begin
      bg_cnt <= bg_cnt + BG_W'(1);
    end
  end

  // DTACK takes priority over a timeout landing in the same cycle.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      zd_q <= 8'h00;
    end else if (state == S_STROBE && zb.DTACK) begin
      zd_q <= zb.ZA[0] ? zb.VD_i[7:0] : zb.VD_i[15:8];
    end else if ((state == S_STROBE && dt_expire) || (state == S_REQ && bg_expire)) begin
      zd_q <= 8'hFF;
    end
  end

  // Serial bank load, LSB first; one shift per rising edge of the write strobe.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      bank_q     <= 9'h000;
      bank_stb_q <= 1'b0;
    end else begin
      bank_stb_q <= bank_stb;
      if (bank_stb && !bank_stb_q) begin
        bank_q <= {zb.ZD_i[0], bank_q[8:1]};
      end
    end
  end

endmodule

// File: tb/tb_zbank_bridge.sv
// Scoreboard bench for zbank_bridge: directed accesses push expected results,
// a negedge monitor accumulates each bus cycle and checks it when ZWAIT drops.
module tb_zbank_bridge;

  typedef struct packed {
    logic [22:0] va;
    logic        uds;
    logic        lds;
    logic        rw;
    logic [15:0] vd;
    logic [7:0]  zd;
    logic [15:0] zwait;
    logic [15:0] req;
    logic [15:0] strobe;
    logic [15:0] to;
    logic        chk_bus;
    logic        chk_zd;
  } exp_t;

  logic       MCLK = 1'b0;
  logic       RESET;
  logic [8:0] bank;
  logic       timeout_flag;

  zbank_bridge_if zif ();

  zbank_bridge #(.TIMEOUT(128), .BG_TIMEOUT(1024)) dut (
    .MCLK         (MCLK),
    .RESET        (RESET),
    .zb           (zif),
    .bank         (bank),
    .timeout_flag (timeout_flag)
  );

  always #5 MCLK = ~MCLK;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // bus responder configuration
  bit          bg_en    = 1'b1;
  int          bg_delay = 0;
  int          dt_delay = 0;
  int          as_busy  = 0;
  logic [15:0] vd_val   = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [22:0] va, input logic uds, input logic lds,
                              input logic rw, input logic [15:0] vd, input logic [7:0] zd,
                              input int zwait, input int req, input int strobe, input int to,
                              input logic chk_bus, input logic chk_zd);
    exp_t e;
    e.va = va; e.uds = uds; e.lds = lds; e.rw = rw; e.vd = vd; e.zd = zd;
    e.zwait = 16'(zwait); e.req = 16'(req); e.strobe = 16'(strobe); e.to = 16'(to);
    e.chk_bus = chk_bus; e.chk_zd = chk_zd;
    return e;
  endfunction

  // 68k side: grant BG after bg_delay REQ cycles, hold AS_i busy, answer DTACK.
  initial begin : responder
    int br_cyc;
    int as_cyc;
    br_cyc = 0;
    as_cyc = 0;
    zif.BG = 1'b0; zif.DTACK = 1'b0; zif.AS_i = 1'b0; zif.VD_i = 16'h0;
    forever begin
      @(posedge MCLK);
      #1;
      br_cyc    = zif.BR ? br_cyc + 1 : 0;
      as_cyc    = zif.AS_o ? as_cyc + 1 : 0;
      zif.AS_i  = (as_busy > 0);
      if (zif.BR && as_busy > 0) as_busy--;
      zif.BG    = bg_en && zif.BR && (br_cyc > bg_delay);
      zif.DTACK = (dt_delay >= 0) && zif.AS_o && (as_cyc > dt_delay);
      zif.VD_i  = vd_val;
    end
  end

  initial begin : monitor
    int          m_zwait, m_req, m_strobe, m_to, m_vdoe, m_vdoe_bad, m_overlap;
    logic [22:0] m_va;
    logic        m_uds, m_lds, m_rw, prev_zwait;
    logic [15:0] m_vd;
    exp_t        e;
    m_zwait = 0; m_req = 0; m_strobe = 0; m_to = 0; m_vdoe = 0; m_vdoe_bad = 0; m_overlap = 0;
    m_va = '0; m_uds = 0; m_lds = 0; m_rw = 0; m_vd = '0; prev_zwait = 0;
    forever begin
      @(negedge MCLK);
      if (RESET) begin
        m_zwait = 0; m_req = 0; m_strobe = 0; m_to = 0; m_vdoe = 0; m_vdoe_bad = 0; m_overlap = 0;
        prev_zwait = 0;
      end else begin
        if (zif.ZWAIT) m_zwait++;
        if (zif.BR) m_req++;
        if (zif.AS_o) begin
          m_strobe++;
          m_va = zif.VA_o; m_uds = zif.UDS_o; m_lds = zif.LDS_o; m_rw = zif.RW_o; m_vd = zif.VD_o;
        end
        if (zif.VD_oe) begin
          m_vdoe++;
          if (!zif.AS_o) m_vdoe_bad++;
        end
        if (timeout_flag) m_to++;
        if (zif.BGACK && zif.AS_i) m_overlap++;
        if (prev_zwait && !zif.ZWAIT) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got completion expected none");
          end else begin
            e = sb.pop_front();
            check("zwait_cycles", m_zwait, 32'(e.zwait));
            check("req_cycles", m_req, 32'(e.req));
            check("strobe_cycles", m_strobe, 32'(e.strobe));
            check("timeout_pulses", m_to, 32'(e.to));
            check("zd_oe", 32'(zif.ZD_oe), 32'(e.rw));
            check("bus_released", {zif.BR, zif.BGACK, zif.VA_oe, zif.strobe_oe}, 0);
            check("bgack_as_overlap", m_overlap, 0);
            check("vd_oe_outside_strobe", m_vdoe_bad, 0);
            if (e.chk_zd) check("zd_o", 32'(zif.ZD_o), 32'(e.zd));
            if (e.chk_bus) begin
              check("va_o", 32'(m_va), 32'(e.va));
              check("uds_lds", {m_uds, m_lds}, {e.uds, e.lds});
              check("rw_o", 32'(m_rw), 32'(e.rw));
              if (!e.rw) begin
                check("vd_o", 32'(m_vd), 32'(e.vd));
                check("vd_oe_cycles", m_vdoe, 1);
              end
            end
          end
          m_zwait = 0; m_req = 0; m_strobe = 0; m_to = 0; m_vdoe = 0; m_vdoe_bad = 0; m_overlap = 0;
        end
        prev_zwait = zif.ZWAIT;
      end
    end
  end

  // All task entry/exit points are at posedge + 2.
  task automatic access(input logic [15:0] a, input logic [7:0] d, input bit rd, input exp_t e);
    int n;
    sb.push_back(e);
    zif.ZA = a; zif.ZD_i = d; zif.ZRD = rd; zif.ZWR = !rd; zif.ZMREQ = 1'b1;
    n = 0;
    @(negedge MCLK);
    while (zif.ZWAIT && n < 3000) begin
      @(negedge MCLK);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL access_wait: ZWAIT still high after %0d cycles, required low", n);
    end
    repeat (3) @(posedge MCLK);
    #2;
    zif.ZMREQ = 1'b0; zif.ZRD = 1'b0; zif.ZWR = 1'b0;
    repeat (2) @(posedge MCLK);
    #2;
  endtask

  task automatic bank_write(input logic b, input int hold);
    zif.ZA = 16'h6000; zif.ZD_i = {7'h55, b}; zif.ZRD = 1'b0; zif.ZWR = 1'b1; zif.ZMREQ = 1'b1;
    repeat (hold) @(posedge MCLK);
    #2;
    zif.ZMREQ = 1'b0; zif.ZWR = 1'b0;
    @(posedge MCLK);
    #2;
  endtask

  task automatic load_bank(input logic [8:0] v);
    for (int i = 0; i < 9; i++) bank_write(v[i], 2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_ctl"}, {zif.ZWAIT, zif.ZD_oe, zif.BR, zif.BGACK, zif.VA_oe, zif.strobe_oe,
                          zif.AS_o, zif.UDS_o, zif.LDS_o, zif.RW_o, zif.VD_oe, timeout_flag}, 12'h004);
    check({tag, "_va_vd_zd"}, {zif.VA_o, zif.VD_o, zif.ZD_o}, 0);
  endtask

  initial begin : stim
    logic seq [9];
    int   n;
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    RESET = 1'b1;
    // hit held during reset must not stall the Z80
    zif.ZA = 16'h8000; zif.ZD_i = 8'h00; zif.ZMREQ = 1'b1; zif.ZRD = 1'b1; zif.ZWR = 1'b0;
    repeat (3) @(posedge MCLK);
    @(negedge MCLK);
    chk_reset_outputs("reset");
    check("reset_bank", 32'(bank), 0);
    @(posedge MCLK);
    #2;
    zif.ZMREQ = 1'b0; zif.ZRD = 1'b0;
    @(posedge MCLK);
    #2;
    RESET = 1'b0;
    @(posedge MCLK);
    #2;

    for (int i = 0; i < 9; i++) bank_write(seq[i], 2);
    check("bank_serial_load", 32'(bank), 32'(9'b101001101));
    zif.ZA = 16'h6000; zif.ZD_i = 8'h01; zif.ZRD = 1'b1; zif.ZMREQ = 1'b1;
    repeat (2) @(posedge MCLK);
    #2;
    zif.ZMREQ = 1'b0; zif.ZRD = 1'b0;
    @(posedge MCLK);
    #2;
    check("bank_read_ignored", 32'(bank), 32'(9'b101001101));
    bank_write(1'b0, 4);
    check("bank_held_write_once", 32'(bank), 32'(9'b010100110));

    // read 0x8005, bank 0x1A3, BG one cycle after BR, DTACK at once
    load_bank(9'h1A3);
    check("bank_1a3", 32'(bank), 32'h1A3);
    bg_en = 1'b1; bg_delay = 1; dt_delay = 0; vd_val = 16'hBEEF;
    access(16'h8005, 8'h00, 1'b1, mk(23'h68C002, 1'b0, 1'b1, 1'b1, 16'h0, 8'hEF, 7, 2, 1, 0, 1'b1, 1'b1));

    // write 0xC000, bank 0, BG already up: minimum latency
    load_bank(9'h000);
    check("bank_zero", 32'(bank), 0);
    bg_delay = 0; vd_val = 16'h0000;
    access(16'hC000, 8'h5A, 1'b0, mk(23'h002000, 1'b1, 1'b0, 1'b0, 16'h5A5A, 8'h00, 6, 1, 1, 0, 1'b1, 1'b0));

    // grant deferred while the previous master holds AS for 4 cycles
    as_busy = 4; vd_val = 16'h1234;
    access(16'h8000, 8'h00, 1'b1, mk(23'h000000, 1'b1, 1'b0, 1'b1, 16'h0, 8'h12, 10, 5, 1, 0, 1'b1, 1'b1));

    // no DTACK: 128 STROBE cycles then forced end
    dt_delay = -1;
    access(16'h8001, 8'h00, 1'b1, mk(23'h000000, 1'b0, 1'b1, 1'b1, 16'h0, 8'hFF, 133, 1, 128, 1, 1'b1, 1'b1));

    // DTACK in the last STROBE cycle wins over the timeout
    dt_delay = 127; vd_val = 16'hA55A;
    access(16'h8001, 8'h00, 1'b1, mk(23'h000000, 1'b0, 1'b1, 1'b1, 16'h0, 8'h5A, 133, 1, 128, 0, 1'b1, 1'b1));

    // BG never granted: 1024 REQ cycles then abandon
    bg_en = 1'b0; dt_delay = 0;
    access(16'h8002, 8'h00, 1'b1, mk(23'h000000, 1'b0, 1'b0, 1'b1, 16'h0, 8'hFF, 1025, 1024, 0, 1, 1'b0, 1'b1));

    // reset while in STROBE
    bg_en = 1'b1; dt_delay = -1;
    load_bank(9'h0F0);
    zif.ZA = 16'h8003; zif.ZD_i = 8'h00; zif.ZRD = 1'b1; zif.ZWR = 1'b0; zif.ZMREQ = 1'b1;
    n = 0;
    @(negedge MCLK);
    while (!zif.AS_o && n < 50) begin
      @(negedge MCLK);
      n++;
    end
    check("reached_strobe", 32'(zif.AS_o), 1);
    @(posedge MCLK);
    #2;
    RESET = 1'b1;
    @(negedge MCLK);
    chk_reset_outputs("reset_in_strobe");
    @(posedge MCLK);
    #2;
    zif.ZMREQ = 1'b0; zif.ZRD = 1'b0;
    @(negedge MCLK);
    chk_reset_outputs("after_reset_edge");
    check("bank_after_reset", 32'(bank), 0);
    @(posedge MCLK);
    #2;
    RESET = 1'b0;
    @(posedge MCLK);
    #2;
    dt_delay = 0; vd_val = 16'hC3A5;
    access(16'h8004, 8'h00, 1'b1, mk(23'h000002, 1'b1, 1'b0, 1'b1, 16'h0, 8'hC3, 6, 1, 1, 0, 1'b1, 1'b1));

    repeat (5) @(posedge MCLK);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
